// File: rtl/mips_pkg.sv
// Shared MIPS writeback types: datapath widths, the zero register index and
// the MEM/WB latch layout.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
  } wb_latch_t;

  function automatic logic [DATA_W-1:0] wb_sel(input wb_latch_t l);
    return l.memtoreg ? l.rdata : l.alu;
  endfunction
endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB instruction bus plus the register-file write port. The WB stage is
// the master: it consumes mem_* and drives the wb_* write.
interface wb_stage_if;
  import mips_pkg::*;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memtoreg;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_writedata;
  logic              wb_regwrite;

  modport master (
    input  mem_valid, mem_rd, mem_regwrite, mem_memtoreg, mem_alu_result, mem_read_data,
    output wb_rd, wb_writedata, wb_regwrite
  );
  modport slave (
    output mem_valid, mem_rd, mem_regwrite, mem_memtoreg, mem_alu_result, mem_read_data,
    input  wb_rd, wb_writedata, wb_regwrite
  );
endinterface

// File: rtl/wb_bypass.sv
// Decode-side bypass compare: flags rs/rt reads that hit the register being
// written this cycle.
module wb_bypass
  import mips_pkg::*;
(
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              a_hit,
  output logic              b_hit
);
  assign a_hit = regwrite && (rs == rd);
  assign b_hit = regwrite && (rt == rd);
endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB latch, result select, write-once regfile write,
// retire counter. Decode bypass is built only when WB_BYPASS_EN is defined.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = mips_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.master        bus,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired
);
  wb_latch_t lat;
  logic      done;  // instruction already wrote while held by a stall

  always_ff @(posedge clk) begin
    if (rst) begin
      lat     <= '0;
      done    <= 1'b0;
      retired <= '0;
    end else if (flush) begin
      lat.valid <= 1'b0;
      done      <= 1'b0;
    end else if (stall) begin
      done <= done | bus.wb_regwrite;
    end else begin
      lat.valid    <= bus.mem_valid;
      lat.rd       <= bus.mem_rd;
      lat.regwrite <= bus.mem_regwrite;
      lat.memtoreg <= bus.mem_memtoreg;
      lat.alu      <= bus.mem_alu_result;
      lat.rdata    <= bus.mem_read_data;
      done         <= 1'b0;
      if (lat.valid) retired <= retired + 1'b1;
    end
  end

  assign bus.wb_rd        = lat.rd;
  assign bus.wb_writedata = wb_sel(lat);
  assign bus.wb_regwrite  = lat.valid && lat.regwrite && (lat.rd != REG_ZERO) && !done;

`ifdef WB_BYPASS_EN
  wb_bypass u_bypass (
    .regwrite (bus.wb_regwrite),
    .rd       (lat.rd),
    .rs       (id_rs),
    .rt       (id_rt),
    .a_hit    (fwd_a_hit),
    .b_hit    (fwd_b_hit)
  );
  assign fwd_data = bus.wb_writedata;
`else
  logic unused_id;
  assign unused_id = ^{id_rs, id_rt};
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
  assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic against an
// instruction-level model (what is in WB, has it written yet, retire count).
module tb_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [4:0]  id_rs, id_rt;
  logic        fwd_a_hit, fwd_b_hit;
  logic [31:0] fwd_data, retired;
  int tests = 0, fails = 0;

  wb_stage_if bus();

  wb_stage dut (
    .clk(clk), .rst(rst), .bus(bus), .stall(stall), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_data(fwd_data), .retired(retired)
  );

  always #5 clk = ~clk;

  // model: the instruction currently sitting in WB
  bit          m_valid, m_rw, m_written;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_ret;

  function automatic bit exp_we();
    return m_valid && m_rw && (m_rd != 5'd0) && !m_written;
  endfunction

  function automatic bit exp_hit(input logic [4:0] r);
`ifdef WB_BYPASS_EN
    return exp_we() && (r == m_rd);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_fwd();
`ifdef WB_BYPASS_EN
    return m_data;
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of MEM input, let the edge happen, advance the model.
  task automatic cyc(input bit v, input logic [4:0] rd, input bit rw, input bit mtr,
                     input logic [31:0] alu, input logic [31:0] rdata,
                     input bit st, input bit fl);
    bit we;
    bus.mem_valid = v; bus.mem_rd = rd; bus.mem_regwrite = rw; bus.mem_memtoreg = mtr;
    bus.mem_alu_result = alu; bus.mem_read_data = rdata;
    stall = st; flush = fl;
    we = exp_we();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_rw = 0; m_written = 0; m_rd = 0; m_data = 0; m_ret = 0;
    end else if (fl) begin
      m_valid = 0; m_written = 0;
    end else if (st) begin
      m_written = m_written | we;
    end else begin
      if (m_valid) m_ret = m_ret + 1;
      m_valid = v; m_rw = rw; m_rd = rd; m_data = mtr ? rdata : alu; m_written = 0;
    end
    #1;
  endtask

  task automatic bubble();
    cyc(0, 5'd0, 0, 0, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; id_rs = 0; id_rt = 0;
    cyc(1, 5'd9, 1, 1, 32'hABCD, 32'h5555, 0, 0);
    cyc(1, 5'd3, 1, 0, 32'h1111, 32'h2222, 0, 0);
    rst = 0;
    tests++; if (bus.wb_regwrite !== 1'b0) begin fails++; $display("FAIL reset_we got %0h want 0", bus.wb_regwrite); end
    tests++; if (bus.wb_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0h want 0", bus.wb_rd); end
    tests++; if (bus.wb_writedata !== 32'd0) begin fails++; $display("FAIL reset_data got %0h want 0", bus.wb_writedata); end
    tests++; if (retired !== 32'd0) begin fails++; $display("FAIL reset_retired got %0h want 0", retired); end
    tests++; if ({fwd_a_hit, fwd_b_hit} !== 2'b00) begin fails++; $display("FAIL reset_hits got %0b want 00", {fwd_a_hit, fwd_b_hit}); end
  endtask

  task automatic test_alu();
    logic [31:0] r0 = m_ret;
    cyc(1, 5'd8, 1, 0, 32'h0000_1234, 32'h9999, 0, 0);
    tests++; if (bus.wb_regwrite !== 1'b1) begin fails++; $display("FAIL alu_we got %0h want 1", bus.wb_regwrite); end
    tests++; if (bus.wb_rd !== 5'd8) begin fails++; $display("FAIL alu_rd got %0d want 8", bus.wb_rd); end
    tests++; if (bus.wb_writedata !== 32'h1234) begin fails++; $display("FAIL alu_data got %0h want 1234", bus.wb_writedata); end
    bubble();
    tests++; if (retired !== r0 + 1) begin fails++; $display("FAIL alu_retired got %0d want %0d", retired, r0 + 1); end
  endtask

  task automatic test_load();
    cyc(1, 5'd9, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0);
    tests++; if (bus.wb_writedata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_data got %0h want deadbeef", bus.wb_writedata); end
    tests++; if (bus.wb_regwrite !== 1'b1) begin fails++; $display("FAIL load_we got %0h want 1", bus.wb_regwrite); end
    bubble();
  endtask

  task automatic test_stall();
    logic [31:0] r0;
    cyc(1, 5'd5, 1, 0, 32'h55, 32'h0, 0, 0);
    r0 = retired;
    tests++; if (bus.wb_regwrite !== 1'b1) begin fails++; $display("FAIL stall_first_we got %0h want 1", bus.wb_regwrite); end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 5'd6, 1, 0, 32'h66, 32'h0, 1, 0);
      tests++; if (bus.wb_regwrite !== 1'b0) begin fails++; $display("FAIL stall_hold_we[%0d] got %0h want 0", i, bus.wb_regwrite); end
      tests++; if (retired !== r0) begin fails++; $display("FAIL stall_hold_retired[%0d] got %0d want %0d", i, retired, r0); end
    end
    bubble();
    tests++; if (retired !== r0 + 1) begin fails++; $display("FAIL stall_release_retired got %0d want %0d", retired, r0 + 1); end
  endtask

  task automatic test_rd0();
    logic [31:0] r0 = retired;
    cyc(1, 5'd0, 1, 0, 32'hFFFF_FFFF, 32'h0, 0, 0);
    tests++; if (bus.wb_regwrite !== 1'b0) begin fails++; $display("FAIL rd0_we got %0h want 0", bus.wb_regwrite); end
    bubble();
    tests++; if (retired !== r0 + 1) begin fails++; $display("FAIL rd0_retired got %0d want %0d", retired, r0 + 1); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] r0;
    cyc(1, 5'd7, 1, 0, 32'h77, 32'h0, 0, 0);
    r0 = retired;
    tests++; if (bus.wb_regwrite !== 1'b1) begin fails++; $display("FAIL sf_first_we got %0h want 1", bus.wb_regwrite); end
    cyc(1, 5'd4, 1, 0, 32'h44, 32'h0, 1, 1);
    tests++; if (bus.wb_regwrite !== 1'b0) begin fails++; $display("FAIL sf_we got %0h want 0", bus.wb_regwrite); end
    tests++; if (retired !== r0) begin fails++; $display("FAIL sf_retired got %0d want %0d", retired, r0); end
    bubble();
    tests++; if (retired !== r0) begin fails++; $display("FAIL sf_after_retired got %0d want %0d", retired, r0); end
  endtask

  task automatic test_bypass();
    cyc(1, 5'd12, 1, 0, 32'hAA, 32'h0, 0, 0);
    id_rs = 5'd12; id_rt = 5'd13; #1;
`ifdef WB_BYPASS_EN
    tests++; if (fwd_a_hit !== 1'b1) begin fails++; $display("FAIL byp_a got %0b want 1", fwd_a_hit); end
    tests++; if (fwd_data !== 32'hAA) begin fails++; $display("FAIL byp_data got %0h want aa", fwd_data); end
`else
    tests++; if (fwd_a_hit !== 1'b0) begin fails++; $display("FAIL byp_a got %0b want 0", fwd_a_hit); end
    tests++; if (fwd_data !== 32'h0) begin fails++; $display("FAIL byp_data got %0h want 0", fwd_data); end
`endif
    tests++; if (fwd_b_hit !== 1'b0) begin fails++; $display("FAIL byp_b got %0b want 0", fwd_b_hit); end
    bubble();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      id_rs = 5'($urandom_range(0, 4));
      id_rt = 5'($urandom_range(0, 4));
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), $urandom, $urandom,
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      tests++; if (bus.wb_regwrite !== exp_we()) begin fails++; $display("FAIL rnd_we[%0d] got %0b want %0b", i, bus.wb_regwrite, exp_we()); end
      tests++; if (bus.wb_rd !== m_rd) begin fails++; $display("FAIL rnd_rd[%0d] got %0d want %0d", i, bus.wb_rd, m_rd); end
      tests++; if (bus.wb_writedata !== m_data) begin fails++; $display("FAIL rnd_data[%0d] got %0h want %0h", i, bus.wb_writedata, m_data); end
      tests++; if (retired !== m_ret) begin fails++; $display("FAIL rnd_retired[%0d] got %0d want %0d", i, retired, m_ret); end
      tests++; if (fwd_a_hit !== exp_hit(id_rs)) begin fails++; $display("FAIL rnd_a_hit[%0d] got %0b want %0b", i, fwd_a_hit, exp_hit(id_rs)); end
      tests++; if (fwd_b_hit !== exp_hit(id_rt)) begin fails++; $display("FAIL rnd_b_hit[%0d] got %0b want %0b", i, fwd_b_hit, exp_hit(id_rt)); end
      tests++; if (fwd_data !== exp_fwd()) begin fails++; $display("FAIL rnd_fwd[%0d] got %0h want %0h", i, fwd_data, exp_fwd()); end
    end
    rst = 0;
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_written = 0; m_rd = 0; m_data = 0; m_ret = 0;
    test_reset();
    test_alu();
    test_load();
    test_stall();
    test_rd0();
    test_stall_flush();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
